// File: rtl/tlv5618_pkg.sv
// Shared definitions for the TLV5618 command sequencer: control-word bit
// positions, request modes, sequencer states and the control-word formatter.
package tlv5618_pkg;

    localparam int BIT_R1  = 15;
    localparam int BIT_SPD = 14;
    localparam int BIT_PWR = 13;
    localparam int BIT_R0  = 12;

    localparam logic [1:0] MODE_BOTH = 2'b00;
    localparam logic [1:0] MODE_B    = 2'b01;
    localparam logic [1:0] MODE_A    = 2'b10;
    localparam logic [1:0] MODE_PD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    function automatic logic [15:0] fmt_word(input logic r1, input logic spd,
                                             input logic pwr, input logic r0,
                                             input logic [11:0] code);
        logic [15:0] w;
        w          = {4'b0000, code};
        w[BIT_R1]  = r1;
        w[BIT_SPD] = spd;
        w[BIT_PWR] = pwr;
        w[BIT_R0]  = r0;
        return w;
    endfunction

endpackage

// File: rtl/tlv5618_ctrl_if.sv
// Request handshake and driver-side frame signals of the TLV5618 sequencer.
interface tlv5618_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [11:0] req_code_a;
    logic [11:0] req_code_b;
    logic [15:0] dac_data;
    logic        dac_start;
    logic        dac_done;

    modport slave (
        input  req_valid, req_mode, req_code_a, req_code_b, dac_done,
        output req_ready, dac_data, dac_start
    );

    modport master (
        output req_valid, req_mode, req_code_a, req_code_b, dac_done,
        input  req_ready, dac_data, dac_start
    );
endinterface

// File: rtl/tlv5618_cyc_timer.sv
// Loadable saturating down-counter; tc_o is high while the count sits at zero.
module tlv5618_cyc_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/tlv5618_ctrl.sv
// TLV5618 command sequencer: turns A/B/power-down requests into one or two
// driver frames, keeping the DAC buffer coherent for single-channel A writes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a request; frame list is built on accept
//   ST_START | one-cycle start pulse to the driver, timeout timer loaded
//   ST_WAIT  | frame held on dac_data until done or timeout
//   ST_GAP   | CS-high gap, then next frame or sequence complete
module tlv5618_ctrl
    import tlv5618_pkg::*;
#(
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SPD_FAST       = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    tlv5618_ctrl_if.slave  bus,
    output logic           busy,
    output logic           seq_done,
    output logic           err_timeout
);
    localparam logic        SPD      = (SPD_FAST != 0);
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] dac_data_q, dac_data_d;
    logic [15:0] f2_q, f2_d;
    logic        f2_pend_q, f2_pend_d;
    logic [1:0]  mode_q, mode_d;
    logic        buf_valid_q, buf_valid_d;
    logic [11:0] shadow_b_q, shadow_b_d;
    logic        seq_done_q, seq_done_d;
    logic        err_q, err_d;
    logic        ready_q;
    logic        tmo_load, tmo_tc, gap_load, gap_tc;
    logic [15:0] word_a;

    assign word_a = fmt_word(1'b1, SPD, 1'b0, 1'b0, bus.req_code_a);

    tlv5618_cyc_timer #(.W(16)) u_tmo (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .en_i       (state_q == ST_WAIT),
        .tc_o       (tmo_tc)
    );

    tlv5618_cyc_timer #(.W(8)) u_gap (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .en_i       (state_q == ST_GAP),
        .tc_o       (gap_tc)
    );

    always_comb begin
        state_d     = state_q;
        dac_data_d  = dac_data_q;
        f2_d        = f2_q;
        f2_pend_d   = f2_pend_q;
        mode_d      = mode_q;
        buf_valid_d = buf_valid_q;
        shadow_b_d  = shadow_b_q;
        seq_done_d  = 1'b0;
        err_d       = err_q;
        tmo_load    = 1'b0;
        gap_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    state_d   = ST_START;
                    mode_d    = bus.req_mode;
                    err_d     = 1'b0;
                    f2_d      = word_a;
                    f2_pend_d = 1'b0;
                    case (bus.req_mode)
                        MODE_BOTH: begin
                            dac_data_d = fmt_word(1'b0, SPD, 1'b0, 1'b1, bus.req_code_b);
                            f2_pend_d  = 1'b1;
                        end
                        MODE_B: dac_data_d = fmt_word(1'b0, SPD, 1'b0, 1'b0, bus.req_code_b);
                        MODE_A: begin
                            // Without a known buffer, re-prime it with the last B so B stays put.
                            if (buf_valid_q) begin
                                dac_data_d = word_a;
                            end else begin
                                dac_data_d = fmt_word(1'b0, SPD, 1'b0, 1'b1, shadow_b_q);
                                f2_pend_d  = 1'b1;
                            end
                        end
                        default: dac_data_d = fmt_word(1'b0, SPD, 1'b1, 1'b1, 12'h000);
                    endcase
                end
            end
            ST_START: begin
                state_d  = ST_WAIT;
                tmo_load = 1'b1;
            end
            ST_WAIT: begin
                if (bus.dac_done) begin
                    state_d  = ST_GAP;
                    gap_load = 1'b1;
                    // Every R1=0 frame loads the double buffer; power-down invalidates it.
                    if (!dac_data_q[BIT_R1]) begin
                        if (mode_q == MODE_PD) begin
                            buf_valid_d = 1'b0;
                        end else begin
                            buf_valid_d = 1'b1;
                            if (mode_q != MODE_A) shadow_b_d = dac_data_q[11:0];
                        end
                    end
                end else if (tmo_tc) begin
                    state_d     = ST_IDLE;
                    err_d       = 1'b1;
                    buf_valid_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_tc) begin
                    if (f2_pend_q) begin
                        dac_data_d = f2_q;
                        f2_pend_d  = 1'b0;
                        state_d    = ST_START;
                    end else begin
                        state_d    = ST_IDLE;
                        seq_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dac_data_q  <= 16'h0000;
            f2_q        <= 16'h0000;
            f2_pend_q   <= 1'b0;
            mode_q      <= MODE_BOTH;
            buf_valid_q <= 1'b0;
            shadow_b_q  <= 12'h000;
            seq_done_q  <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            dac_data_q  <= dac_data_d;
            f2_q        <= f2_d;
            f2_pend_q   <= f2_pend_d;
            mode_q      <= mode_d;
            buf_valid_q <= buf_valid_d;
            shadow_b_q  <= shadow_b_d;
            seq_done_q  <= seq_done_d;
            err_q       <= err_d;
            ready_q     <= (state_d == ST_IDLE);
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.dac_data  = dac_data_q;
    assign bus.dac_start = (state_q == ST_START);
    assign busy          = !ready_q;
    assign seq_done      = seq_done_q;
    assign err_timeout   = err_q;
endmodule

// File: tb/tb_tlv5618_ctrl.sv
// Bench for tlv5618_ctrl: directed and random request sequences against a
// behavioural model of the frame list, buffer and shadow-B tracking.
module tb_tlv5618_ctrl;
    localparam int GAP   = 4;
    localparam int TMO   = 60;
    localparam int NDIR  = 9;
    localparam int NRAND = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, seq_done, err_timeout;
    logic done_drv = 1'b0, done_stray = 1'b0, drv_mute = 1'b0;
    int   drv_delay = 5;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [15:0] st_w[$], dn_w[$], exp_q[$];
    int          st_c[$], dn_c[$];
    logic        bv_m = 1'b0;
    logic [11:0] sh_m = 12'h000;
    int          rdy_c, n_sd, bad_busy, acc_c;
    bit          to;

    logic [1:0]  dir_m [NDIR] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [11:0] dir_a [NDIR] = '{12'hABC, 12'h001, 12'h000, 12'h010, 12'h000, 12'h222, 12'h123, 12'h000, 12'hAAA};
    logic [11:0] dir_b [NDIR] = '{12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h456, 12'h3C5, 12'h555};
    int          dir_d [NDIR] = '{10, 7, 12, 5, 3, 9, 40, TMO, 1};

    tlv5618_ctrl_if bus();
    assign bus.dac_done = done_drv | done_stray;

    tlv5618_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .SPD_FAST(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .seq_done    (seq_done),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver model: log each start, answer with done drv_delay cycles later.
    always begin
        @(negedge clk);
        if (rst_n && bus.dac_start === 1'b1) begin
            st_w.push_back(bus.dac_data);
            st_c.push_back(cyc);
            if (!drv_mute) begin
                repeat (drv_delay) @(negedge clk);
                dn_w.push_back(bus.dac_data);
                dn_c.push_back(cyc);
                done_drv = 1'b1;
                @(negedge clk);
                done_drv = 1'b0;
            end
        end
    end

    // Word layout {R1,SPD,PWR,R0,code}, SPD fixed at 1.
    task automatic model_frames(input logic [1:0] m, input logic [11:0] a, input logic [11:0] b);
        exp_q.delete();
        case (m)
            2'b00: begin exp_q.push_back({4'b0101, b}); exp_q.push_back({4'b1100, a}); end
            2'b01: exp_q.push_back({4'b0100, b});
            2'b10: begin
                if (!bv_m) exp_q.push_back({4'b0101, sh_m});
                exp_q.push_back({4'b1100, a});
            end
            default: exp_q.push_back(16'h7000);
        endcase
    endtask

    task automatic model_commit(input logic [1:0] m, input logic [11:0] b);
        if (m == 2'b00 || m == 2'b01) sh_m = b;
        bv_m = (m != 2'b11);
    endtask

    task automatic send_req(input logic [1:0] m, input logic [11:0] a, input logic [11:0] b, input bit garbage);
        int k;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k == 200) begin
            $display("FAIL send_req: req_ready=%b, required 1", bus.req_ready);
            $fatal(1, "req_ready stuck low");
        end
        st_w.delete(); st_c.delete(); dn_w.delete(); dn_c.delete();
        bus.req_valid  = 1'b1;
        bus.req_mode   = m;
        bus.req_code_a = a;
        bus.req_code_b = b;
        acc_c = cyc;
        @(negedge clk);
        bus.req_valid  = garbage & 1'($urandom);
        bus.req_mode   = 2'($urandom);
        bus.req_code_a = 12'($urandom);
        bus.req_code_b = 12'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        n_sd = 0; bad_busy = 0; to = 1'b1; rdy_c = -1;
        for (int k = 0; k < budget; k++) begin
            if (busy !== ~bus.req_ready) bad_busy++;
            if (seq_done === 1'b1) n_sd++;
            if (bus.req_ready === 1'b1) begin
                bus.req_valid = 1'b0;
                rdy_c = cyc;
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (seq_done === 1'b1) n_sd++;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_mode = 2'b00; bus.req_code_a = '0; bus.req_code_b = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b need 1", bus.req_ready); end
        total++; if (bus.dac_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h need 0000", bus.dac_data); end
        total++; if (bus.dac_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b need 0", bus.dac_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b need 0", busy); end
        total++; if (seq_done !== 1'b0) begin bad++; $display("FAIL reset_seq_done: got %b need 0", seq_done); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err: got %b need 0", err_timeout); end
        rst_n = 1'b1;
        bv_m = 1'b0; sh_m = 12'h000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sequences();
        logic [1:0]  m;
        logic [11:0] a, b;
        for (int i = 0; i < NDIR + NRAND; i++) begin
            if (i < NDIR) begin
                m = dir_m[i]; a = dir_a[i]; b = dir_b[i]; drv_delay = dir_d[i];
            end else begin
                m = 2'($urandom_range(0, 3)); a = 12'($urandom); b = 12'($urandom);
                drv_delay = $urandom_range(1, TMO);
            end
            model_frames(m, a, b);
            send_req(m, a, b, i >= NDIR);
            wait_idle(2000);
            total++; if (to) begin bad++; $display("FAIL seq%0d_idle: req_ready stayed %b, need 1", i, bus.req_ready); end
            total++; if (st_w.size() != exp_q.size()) begin bad++; $display("FAIL seq%0d_nframes: got %0d need %0d", i, st_w.size(), exp_q.size()); end
            for (int j = 0; j < st_w.size() && j < exp_q.size(); j++) begin
                total++; if (st_w[j] !== exp_q[j]) begin bad++; $display("FAIL seq%0d_word%0d: got %h need %h", i, j, st_w[j], exp_q[j]); end
                if (j < dn_w.size()) begin
                    total++; if (dn_w[j] !== exp_q[j]) begin bad++; $display("FAIL seq%0d_hold%0d: got %h need %h", i, j, dn_w[j], exp_q[j]); end
                end
            end
            if (st_c.size() > 0) begin
                total++; if (st_c[0] != acc_c + 1) begin bad++; $display("FAIL seq%0d_lat: start at %0d need %0d", i, st_c[0], acc_c + 1); end
            end
            if (st_c.size() > 1 && dn_c.size() > 0) begin
                total++; if (st_c[1] != dn_c[0] + GAP + 1) begin bad++; $display("FAIL seq%0d_gap: start2 at %0d need %0d", i, st_c[1], dn_c[0] + GAP + 1); end
            end
            if (dn_c.size() > 0 && !to) begin
                total++; if (rdy_c != dn_c[dn_c.size()-1] + GAP + 1) begin bad++; $display("FAIL seq%0d_ready: at %0d need %0d", i, rdy_c, dn_c[dn_c.size()-1] + GAP + 1); end
            end
            total++; if (n_sd != 1) begin bad++; $display("FAIL seq%0d_seq_done: pulses %0d need 1", i, n_sd); end
            total++; if (bad_busy != 0) begin bad++; $display("FAIL seq%0d_busy: %0d cycles busy!=!ready, need 0", i, bad_busy); end
            total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL seq%0d_err: got %b need 0", i, err_timeout); end
            model_commit(m, b);
        end
    endtask

    task automatic test_timeout();
        logic [11:0] a, b;
        b = 12'($urandom);
        drv_mute = 1'b1;
        send_req(2'b01, 12'h000, b, 1'b0);
        wait_idle(TMO + 50);
        total++; if (to || rdy_c != acc_c + TMO + 2) begin bad++; $display("FAIL tmo_latency: ready at %0d need %0d", rdy_c, acc_c + TMO + 2); end
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b need 1", err_timeout); end
        total++; if (n_sd != 0) begin bad++; $display("FAIL tmo_seq_done: pulses %0d need 0", n_sd); end
        total++; if (st_w.size() != 1) begin bad++; $display("FAIL tmo_frames: got %0d need 1", st_w.size()); end
        bv_m = 1'b0;
        drv_mute = 1'b0;
        drv_delay = 6;
        a = 12'($urandom);
        send_req(2'b10, a, 12'($urandom), 1'b0);
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b need 0", err_timeout); end
        wait_idle(2000);
        total++; if (st_w.size() != 2 || st_w[0] !== {4'b0101, sh_m} || st_w[1] !== {4'b1100, a}) begin
            bad++; $display("FAIL tmo_reprime: got %0d frames %h %h need %h %h", st_w.size(), st_w[0], st_w[1], {4'b0101, sh_m}, {4'b1100, a});
        end
        model_commit(2'b10, 12'h000);
    endtask

    task automatic test_reset_mid();
        int bad_i;
        drv_delay = 40;
        send_req(2'b00, 12'h9AB, 12'h3CD, 1'b0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({bus.req_ready, busy, bus.dac_start, seq_done, err_timeout, bus.dac_data} !== {5'b10000, 16'h0000}) begin
            bad++; $display("FAIL rst_async: ready/busy/start/done/err/data got %b%b%b%b%b %h need 10000 0000",
                            bus.req_ready, busy, bus.dac_start, seq_done, err_timeout, bus.dac_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bv_m = 1'b0; sh_m = 12'h000;
        bad_i = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 20) done_stray = 1'b1;
            if (k == 21) done_stray = 1'b0;
            if (bus.dac_data !== 16'h0000 || bus.req_ready !== 1'b1 || seq_done !== 1'b0 || bus.dac_start !== 1'b0) bad_i++;
        end
        total++; if (bad_i != 0) begin bad++; $display("FAIL rst_stray: %0d idle cycles changed, need 0", bad_i); end
        total++; if (st_w.size() != 1) begin bad++; $display("FAIL rst_no_f2: got %0d frames need 1", st_w.size()); end
        drv_delay = 8;
        send_req(2'b10, 12'hABC, 12'h000, 1'b0);
        wait_idle(2000);
        total++; if (st_w.size() != 2 || st_w[0] !== 16'h5000 || st_w[1] !== 16'hCABC) begin
            bad++; $display("FAIL rst_reprime: got %0d frames %h %h need 5000 CABC", st_w.size(), st_w[0], st_w[1]);
        end
        total++; if (n_sd != 1) begin bad++; $display("FAIL rst_reprime_done: pulses %0d need 1", n_sd); end
        model_commit(2'b10, 12'h000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequences();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
